// File: rtl/battleship_master_ctrl_if.sv
// Signal bundle between the player-A controller and the rest of the board (switches, buttons, slave datapath).
// The master side is the controller; the slave side is whoever drives the board inputs.
interface battleship_master_ctrl_if #(
    parameter int N = 10
);
    logic [N-1:0] A_sw;
    logic         BTN1A;
    logic         BTN2A;
    logic         BTN3A;
    logic         BTN1B;
    logic         BTN2B;
    logic         BTN3B;
    logic [N-1:0] B_Attack;
    logic         LivB;
    logic         ST;
    logic         LDR2B;
    logic         game_clr;
    logic [N-1:0] A_Attack;
    logic [2:0]   DispA;
    logic [2:0]   DispB;
    logic         LivA;
    logic [N-1:0] ShipsA;
    logic [2:0]   dbg_state;

    modport master (
        input  A_sw, BTN1A, BTN2A, BTN3A, BTN1B, BTN2B, BTN3B, B_Attack, LivB,
        output ST, LDR2B, game_clr, A_Attack, DispA, DispB, LivA, ShipsA, dbg_state
    );

    modport slave (
        output A_sw, BTN1A, BTN2A, BTN3A, BTN1B, BTN2B, BTN3B, B_Attack, LivB,
        input  ST, LDR2B, game_clr, A_Attack, DispA, DispB, LivA, ShipsA, dbg_state
    );
endinterface

// File: rtl/battleship_master_ctrl.sv
// Player-A game controller: owns A's ships and attack mask, runs the turn FSM and drives the slave board.
// Handshake: LDR2B is a one-cycle strobe; the slave's B_Attack is valid in the following cycle (LATCH_B).
module battleship_master_ctrl #(
    parameter int N        = 10,
    parameter int SHIPS    = 3,
    parameter int HOLD_CYC = 100_000_000
) (
    input  logic                    clk,
    input  logic                    clr,
    battleship_master_ctrl_if.master bus
);
    localparam int CW = $clog2(HOLD_CYC);
    localparam int PW = $clog2(N + 1);

    localparam logic [2:0] W_PLACE = 3'd1, W_WAIT = 3'd2, W_FIRE = 3'd3,
                           W_SHOT = 3'd4, W_ERR = 3'd5, W_WIN = 3'd6, W_LOSE = 3'd7;

    typedef enum logic [2:0] {
        S_SETUP   = 3'd0,
        S_TURN_A  = 3'd1,
        S_SHOT_A  = 3'd2,
        S_TURN_B  = 3'd3,
        S_LATCH_B = 3'd4,
        S_SHOT_B  = 3'd5,
        S_A_WIN   = 3'd6,
        S_B_WIN   = 3'd7
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] ships_q, ships_d, a_att_q, a_att_d, bprev_q, bprev_d;
    logic         rdya_q, rdya_d, rdyb_q, rdyb_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [5:0]   btn_raw, btn_s1_q, btn_s2_q, btn_s3_q, btn_pulse;
    logic [N-1:0] a_new, b_new;
    logic         st, ldr2b, new_game;
    logic [2:0]   disp_a, disp_b;

    function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
        popcnt = '0;
        for (int i = 0; i < N; i++) popcnt = popcnt + PW'(v[i]);
    endfunction

    function automatic logic single_new(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Synchronisers are deliberately left out of reset so a button held across clr does not re-trigger.
    assign btn_raw = {bus.BTN3B, bus.BTN2B, bus.BTN1B, bus.BTN3A, bus.BTN2A, bus.BTN1A};
    always_ff @(posedge clk) begin
        btn_s1_q <= btn_raw;
        btn_s2_q <= btn_s1_q;
        btn_s3_q <= btn_s2_q;
    end
    assign btn_pulse = btn_s2_q & ~btn_s3_q;

    assign a_new = bus.A_sw & ~a_att_q;
    assign b_new = bus.B_Attack & ~bprev_q;

    always_comb begin
        state_d  = state_q;
        ships_d  = ships_q;
        a_att_d  = a_att_q;
        bprev_d  = bprev_q;
        rdya_d   = rdya_q;
        rdyb_d   = rdyb_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        st       = 1'b1;
        ldr2b    = 1'b0;
        new_game = 1'b0;
        disp_a   = 3'd0;
        disp_b   = 3'd0;
        case (state_q)
            S_SETUP: begin
                st     = 1'b0;
                disp_a = err_q ? W_ERR : (rdya_q ? W_WAIT : W_PLACE);
                disp_b = rdyb_q ? W_WAIT : W_PLACE;
                if (rdya_q && rdyb_q && bus.LivB) begin
                    state_d = S_TURN_A;
                    err_d   = 1'b0;
                end else begin
                    ships_d = bus.A_sw;
                    if (btn_pulse[0]) begin
                        if (popcnt(bus.A_sw) == PW'(SHIPS)) begin
                            rdya_d = 1'b1;
                            err_d  = 1'b0;
                        end else begin
                            err_d  = 1'b1;
                        end
                    end
                    if (btn_pulse[3]) rdyb_d = 1'b1;
                end
            end
            S_TURN_A: begin
                disp_a = err_q ? W_ERR : W_FIRE;
                disp_b = W_WAIT;
                if (btn_pulse[1]) begin
                    if (single_new(a_new)) begin
                        a_att_d = a_att_q | a_new;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_SHOT_A;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_SHOT_A, S_SHOT_B: begin
                disp_a = W_SHOT;
                disp_b = W_SHOT;
                if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    cnt_d = '0;
                    if (state_q == S_SHOT_A) state_d = bus.LivB ? S_TURN_B : S_A_WIN;
                    else                     state_d = (|ships_q) ? S_TURN_A : S_B_WIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TURN_B: begin
                disp_a = W_WAIT;
                disp_b = err_q ? W_ERR : W_FIRE;
                if (btn_pulse[4]) begin
                    ldr2b   = 1'b1;
                    state_d = S_LATCH_B;
                end
            end
            S_LATCH_B: begin
                disp_a = W_WAIT;
                disp_b = err_q ? W_ERR : W_FIRE;
                if (single_new(b_new)) begin
                    bprev_d = bprev_q | b_new;
                    ships_d = ships_q & ~b_new;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHOT_B;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_TURN_B;
                end
            end
            S_A_WIN: begin
                disp_a   = W_WIN;
                disp_b   = W_LOSE;
                new_game = btn_pulse[2] | btn_pulse[5];
            end
            S_B_WIN: begin
                disp_a   = W_LOSE;
                disp_b   = W_WIN;
                new_game = btn_pulse[2] | btn_pulse[5];
            end
            default: state_d = S_SETUP;
        endcase
        if (new_game) begin
            state_d = S_SETUP;
            ships_d = '0;
            a_att_d = '0;
            bprev_d = '0;
            rdya_d  = 1'b0;
            rdyb_d  = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_SETUP;
            ships_q <= '0;
            a_att_q <= '0;
            bprev_q <= '0;
            rdya_q  <= 1'b0;
            rdyb_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ships_q <= ships_d;
            a_att_q <= a_att_d;
            bprev_q <= bprev_d;
            rdya_q  <= rdya_d;
            rdyb_q  <= rdyb_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // clr overrides the state-derived outputs so the reset cycle already looks like a fresh SETUP.
    assign bus.ST        = st & ~clr;
    assign bus.LDR2B     = ldr2b & ~clr;
    assign bus.game_clr  = clr | new_game;
    assign bus.DispA     = clr ? W_PLACE : disp_a;
    assign bus.DispB     = clr ? W_PLACE : disp_b;
    assign bus.LivA      = ~clr & (|ships_q);
    assign bus.A_Attack  = a_att_q;
    assign bus.ShipsA    = ships_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_battleship_master_ctrl.sv
// Bench for the player-A controller: vector table through a scoreboard queue, plus reset/abort sequences.
module tb_battleship_master_ctrl;
    localparam int N    = 10;
    localparam int HOLD = 4;
    localparam int W    = 31;

    typedef struct {
        logic [5:0]   btn;   // {3B,2B,1B,3A,2A,1A}
        logic [N-1:0] a_sw;
        logic [N-1:0] b_att;
        logic         livb;
        int           wait_cyc;
        logic [W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    battleship_master_ctrl_if #(.N(N)) bus ();

    battleship_master_ctrl #(.N(N), .SHIPS(3), .HOLD_CYC(HOLD)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[26];

    int   ldr_cycles = 0, ldr_rises = 0, gclr_cycles = 0, excl_viol = 0;
    logic ldr_prev = 1'b0;

    always @(negedge clk) begin
        if (!clr) begin
            if (bus.LDR2B) ldr_cycles++;
            if (bus.LDR2B && !ldr_prev) ldr_rises++;
            if (bus.game_clr) gclr_cycles++;
            if (bus.LDR2B && bus.game_clr) excl_viol++;
        end
        ldr_prev = bus.LDR2B;
    end

    function automatic logic [W-1:0] pack(input logic [2:0] s, input logic [2:0] da, input logic [2:0] db,
                                          input logic st, input logic [N-1:0] aa, input logic [N-1:0] sh,
                                          input logic lv);
        return {s, da, db, st, aa, sh, lv};
    endfunction

    function automatic vec_t mk(input logic [5:0] btn, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic lb, input int w, input logic [2:0] s, input logic [2:0] da,
                                input logic [2:0] db, input logic st, input logic [N-1:0] aa,
                                input logic [N-1:0] sh, input logic lv);
        vec_t v;
        v.btn = btn; v.a_sw = a; v.b_att = b; v.livb = lb; v.wait_cyc = w;
        v.exp = pack(s, da, db, st, aa, sh, lv);
        return v;
    endfunction

    function automatic logic [W-1:0] observe();
        return pack(bus.dbg_state, bus.DispA, bus.DispB, bus.ST, bus.A_Attack, bus.ShipsA, bus.LivA);
    endfunction

    task automatic set_btn(input logic [5:0] b);
        bus.BTN1A = b[0]; bus.BTN2A = b[1]; bus.BTN3A = b[2];
        bus.BTN1B = b[3]; bus.BTN2B = b[4]; bus.BTN3B = b[5];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [W-1:0] e;
        bus.A_sw = v.a_sw; bus.B_Attack = v.b_att; bus.LivB = v.livb;
        set_btn(v.btn);
        exp_q.push_back(v.exp);
        @(negedge clk);
        set_btn(6'd0);
        repeat (v.wait_cyc) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (observe() !== e) begin
            errors++;
            $display("FAIL vec%0d {state,dA,dB,ST,AAtt,Ships,LivA}: got %0h expected %0h", idx, observe(), e);
        end
    endtask

    initial begin
        //                 btn        a_sw    b_att  lb w  st  dA  dB ST AAtt    Ships   LivA
        vecs[0]  = mk(6'h00, 10'h00F, 10'h000, 1, 3, 0, 1, 1, 0, 10'h000, 10'h00F, 1);
        vecs[1]  = mk(6'h01, 10'h00F, 10'h000, 1, 3, 0, 5, 1, 0, 10'h000, 10'h00F, 1);
        vecs[2]  = mk(6'h01, 10'h007, 10'h000, 1, 3, 0, 2, 1, 0, 10'h000, 10'h007, 1);
        vecs[3]  = mk(6'h08, 10'h007, 10'h000, 1, 3, 1, 3, 2, 1, 10'h000, 10'h007, 1);
        vecs[4]  = mk(6'h02, 10'h001, 10'h000, 1, 3, 2, 4, 4, 1, 10'h001, 10'h007, 1);
        vecs[5]  = mk(6'h00, 10'h001, 10'h004, 1, 6, 3, 2, 3, 1, 10'h001, 10'h007, 1);
        vecs[6]  = mk(6'h10, 10'h001, 10'h004, 1, 3, 5, 4, 4, 1, 10'h001, 10'h003, 1);
        vecs[7]  = mk(6'h00, 10'h001, 10'h004, 1, 6, 1, 3, 2, 1, 10'h001, 10'h003, 1);
        vecs[8]  = mk(6'h02, 10'h007, 10'h004, 1, 3, 1, 5, 2, 1, 10'h001, 10'h003, 1);
        vecs[9]  = mk(6'h02, 10'h003, 10'h004, 1, 3, 2, 4, 4, 1, 10'h003, 10'h003, 1);
        vecs[10] = mk(6'h00, 10'h003, 10'h004, 1, 6, 3, 2, 3, 1, 10'h003, 10'h003, 1);
        vecs[11] = mk(6'h10, 10'h003, 10'h004, 1, 3, 3, 2, 5, 1, 10'h003, 10'h003, 1);
        vecs[12] = mk(6'h10, 10'h003, 10'h006, 1, 3, 5, 4, 4, 1, 10'h003, 10'h001, 1);
        vecs[13] = mk(6'h00, 10'h003, 10'h006, 1, 6, 1, 3, 2, 1, 10'h003, 10'h001, 1);
        vecs[14] = mk(6'h02, 10'h00B, 10'h006, 1, 3, 2, 4, 4, 1, 10'h00B, 10'h001, 1);
        vecs[15] = mk(6'h00, 10'h00B, 10'h006, 1, 6, 3, 2, 3, 1, 10'h00B, 10'h001, 1);
        vecs[16] = mk(6'h10, 10'h00B, 10'h007, 1, 3, 5, 4, 4, 1, 10'h00B, 10'h000, 0);
        vecs[17] = mk(6'h00, 10'h00B, 10'h007, 1, 6, 7, 7, 6, 1, 10'h00B, 10'h000, 0);
        vecs[18] = mk(6'h02, 10'h010, 10'h007, 1, 3, 7, 7, 6, 1, 10'h00B, 10'h000, 0);
        vecs[19] = mk(6'h20, 10'h010, 10'h000, 1, 3, 0, 1, 1, 0, 10'h000, 10'h010, 1);
        vecs[20] = mk(6'h04, 10'h010, 10'h000, 1, 3, 0, 1, 1, 0, 10'h000, 10'h010, 1);
        vecs[21] = mk(6'h09, 10'h007, 10'h000, 0, 3, 0, 2, 2, 0, 10'h000, 10'h007, 1);
        vecs[22] = mk(6'h00, 10'h007, 10'h000, 1, 3, 1, 3, 2, 1, 10'h000, 10'h007, 1);
        vecs[23] = mk(6'h02, 10'h001, 10'h000, 0, 3, 2, 4, 4, 1, 10'h001, 10'h007, 1);
        vecs[24] = mk(6'h00, 10'h001, 10'h000, 0, 6, 6, 6, 7, 1, 10'h001, 10'h007, 1);
        vecs[25] = mk(6'h04, 10'h007, 10'h000, 0, 3, 0, 1, 1, 0, 10'h000, 10'h007, 1);

        bus.A_sw = '0; bus.B_Attack = '0; bus.LivB = 1'b1;
        set_btn(6'd0);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_game_clr", 32'(bus.game_clr), 32'd1);
        check("rst_disp", {26'd0, bus.DispA, bus.DispB}, {26'd0, 3'd1, 3'd1});
        check("rst_st_liva_ldr", {29'd0, bus.ST, bus.LivA, bus.LDR2B}, 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        check("post_rst_game_clr", 32'(bus.game_clr), 32'd0);
        check("post_rst_regs", {12'd0, bus.A_Attack, bus.ShipsA}, 32'd0);

        for (int i = 0; i < 26; i++) apply(vecs[i], i);

        // Abort a shot mid-hold while fire stays held through the next setup.
        bus.LivB = 1'b1; bus.A_sw = 10'h007;
        set_btn(6'h09);
        @(negedge clk);
        set_btn(6'h00);
        repeat (4) @(negedge clk);
        check("abort_turn_a", 32'(bus.dbg_state), 32'd1);
        bus.A_sw = 10'h001;
        set_btn(6'h02);
        repeat (4) @(negedge clk);
        check("abort_in_shot", 32'(bus.dbg_state), 32'd2);
        clr = 1'b1;
        @(negedge clk);
        check("abort_clr_outs", {24'd0, bus.game_clr, bus.ST, bus.LivA, bus.DispA, bus.LDR2B, 1'b0},
              {24'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0});
        clr = 1'b0;
        @(negedge clk);
        check("abort_setup", {19'd0, bus.dbg_state, bus.A_Attack}, 32'd0);
        bus.A_sw = 10'h007;
        set_btn(6'h0B);
        @(negedge clk);
        set_btn(6'h02);
        repeat (4) @(negedge clk);
        check("held_turn_a", 32'(bus.dbg_state), 32'd1);
        repeat (6) @(negedge clk);
        check("held_fire_once", {19'd0, bus.dbg_state, bus.A_Attack}, {19'd0, 3'd1, 10'h000});
        set_btn(6'h00);
        repeat (2) @(negedge clk);

        check("ldr2b_cycles", 32'(ldr_cycles), 32'd4);
        check("ldr2b_pulses", 32'(ldr_rises), 32'd4);
        check("game_clr_cycles", 32'(gclr_cycles), 32'd2);
        check("ldr_gclr_exclusive", 32'(excl_viol), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
